// File: rtl/corefifo_gray_ptr_sync_pkg.sv
// Shared constants and gray/binary helpers for the FIFO pointer crossing.
// Helpers work on 32-bit zero-extended values; callers size-cast to the pointer width.
package corefifo_pkg;

  localparam int                    ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0]  ERR_CNT_MAX = 8'hFF;

  function automatic int ptr_width(input int addrwidth);
    return addrwidth + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; upper zero bits leave the low result untouched.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/corefifo_gray_ptr_sync_if.sv
// Pointer-crossing bundle: source-domain gray pointer in, synchronized/decoded pointer out.
interface corefifo_gray_ptr_sync_if
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = 3
);
  localparam int PW = ptr_width(ADDRWIDTH);

  logic [PW-1:0]        inp;
  logic                 err_clr;
  logic [PW-1:0]        sync_gray;
  logic [PW-1:0]        sync_bin;
  logic [PW-1:0]        delta;
  logic                 ptr_upd;
  logic                 ptr_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output inp, err_clr,
    input  sync_gray, sync_bin, delta, ptr_upd, ptr_err, err_cnt
  );

  modport slave (
    input  inp, err_clr,
    output sync_gray, sync_bin, delta, ptr_upd, ptr_err, err_cnt
  );

endinterface

// File: rtl/corefifo_gray_ptr_sync_sync_chain.sv
// NUM_STAGES-deep flop chain for an asynchronous multi-bit gray value; reset loads RST_VAL.
// Latency NUM_STAGES edges, no logic ahead of the first stage.
module corefifo_sync_chain #(
  parameter int             NUM_STAGES = 2,
  parameter int             W          = 4,
  parameter logic [W-1:0]   RST_VAL    = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_stage [NUM_STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_stage[k] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_dat;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_dat = r_stage[NUM_STAGES-1];

endmodule

// File: rtl/corefifo_gray_ptr_sync.sv
// Gray pointer synchronizer + registered binary decode, advance delta, update strobe and integrity check.
// Optional saturating error counter enabled by COREFIFO_PTR_ERR_CNT_EN; otherwise err_cnt reads 0.
module corefifo_gray_ptr_sync
  import corefifo_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int ADDRWIDTH  = 3,
  parameter int RESET_PTR  = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  corefifo_gray_ptr_sync_if.slave  bus
);

  localparam int            PW       = ptr_width(ADDRWIDTH);
  localparam logic [PW-1:0] RST_BIN  = PW'(RESET_PTR);
  localparam logic [PW-1:0] RST_GRAY = PW'(bin2gray(32'(RESET_PTR)));
  localparam logic [PW-1:0] DEPTH    = PW'(2 ** ADDRWIDTH);

  generate
    if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
      $error("corefifo_gray_ptr_sync: NUM_STAGES must be 2..4");
    end
  endgenerate

  logic [PW-1:0] w_sync_gray;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_delta_next;
  logic          w_illegal;

  logic [PW-1:0] r_sync_bin;
  logic [PW-1:0] r_delta;
  logic          r_ptr_upd;
  logic          r_ptr_err;

  corefifo_sync_chain #(
    .NUM_STAGES (NUM_STAGES),
    .W          (PW),
    .RST_VAL    (RST_GRAY)
  ) u_sync_chain (
    .clk   (clk),
    .rstn  (rstn),
    .i_dat (bus.inp),
    .o_dat (w_sync_gray)
  );

  assign w_bin_next   = PW'(gray2bin(32'(w_sync_gray)));
  assign w_delta_next = w_bin_next - r_sync_bin;
  // Anything beyond one full FIFO depth means backward movement or a corrupted sample.
  assign w_illegal    = (w_delta_next > DEPTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync_bin <= RST_BIN;
      r_delta    <= '0;
      r_ptr_upd  <= 1'b0;
    end else begin
      r_sync_bin <= w_bin_next;
      r_delta    <= w_delta_next;
      r_ptr_upd  <= (w_bin_next != r_sync_bin);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr_err <= 1'b0;
    end else if (w_illegal) begin
      r_ptr_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_ptr_err <= 1'b0;
    end
  end

`ifdef COREFIFO_PTR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // A new error on the clearing edge restarts the count at one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_cnt <= '0;
    end else if (w_illegal) begin
      if (bus.err_clr)
        r_err_cnt <= ERR_CNT_W'(1);
      else if (r_err_cnt != ERR_CNT_MAX)
        r_err_cnt <= r_err_cnt + 1'b1;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.sync_gray = w_sync_gray;
  assign bus.sync_bin  = r_sync_bin;
  assign bus.delta     = r_delta;
  assign bus.ptr_upd   = r_ptr_upd;
  assign bus.ptr_err   = r_ptr_err;

endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
// Scoreboard bench: stimulus pushes per-edge expectations from a pointer-history model; a negedge monitor pops and compares.
module tb_corefifo_gray_ptr_sync;

  localparam int NS = 2;
  localparam int AW = 3;
  localparam int RP = 0;
`ifdef COREFIFO_PTR_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] d;
    logic       u;
    logic       e;
    logic [7:0] c;
  } exp_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  exp_t q[$];

  logic [3:0] h [NS+2];
  int         m_err;
  int         m_cnt;
  int         src;

  corefifo_gray_ptr_sync_if #(.ADDRWIDTH(AW)) bus ();

  corefifo_gray_ptr_sync #(
    .NUM_STAGES (NS),
    .ADDRWIDTH  (AW),
    .RESET_PTR  (RP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] gr(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  // Inverse by search over the code table, not by bit manipulation.
  function automatic int g2b(input logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (gr(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS + 2; i++) h[i] = gr(RP);
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sync_gray", 32'(bus.sync_gray), 32'(gr(RP)));
    chk("rst_sync_bin",  32'(bus.sync_bin),  32'(RP));
    chk("rst_delta",     32'(bus.delta),     32'd0);
    chk("rst_ptr_upd",   32'(bus.ptr_upd),   32'd0);
    chk("rst_ptr_err",   32'(bus.ptr_err),   32'd0);
    chk("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
  endtask

  // One clock: drive at negedge, then predict the outputs after the following posedge.
  task automatic step(input logic [3:0] g, input logic clr);
    exp_t x;
    int   bn;
    int   bo;
    int   d;
    @(negedge clk);
    bus.inp     = g;
    bus.err_clr = clr;
    @(posedge clk);
    for (int i = NS + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = g;
    bn = g2b(h[NS]);
    bo = g2b(h[NS+1]);
    d  = (bn - bo + 16) % 16;
    if (d > (1 << AW)) begin
      m_err = 1;
      m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_err = 0;
      m_cnt = 0;
    end
    x.g = h[NS-1];
    x.b = 4'(bn);
    x.d = 4'(d);
    x.u = (bn != bo);
    x.e = (m_err != 0);
    x.c = CNT_EN ? 8'(m_cnt) : 8'd0;
    q.push_back(x);
  endtask

  task automatic hold(input logic [3:0] g, input int n, input logic clr_last);
    for (int i = 0; i < n; i++) step(g, (i == n - 1) ? clr_last : 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("sync_gray", 32'(bus.sync_gray), 32'(x.g));
      chk("sync_bin",  32'(bus.sync_bin),  32'(x.b));
      chk("delta",     32'(bus.delta),     32'(x.d));
      chk("ptr_upd",   32'(bus.ptr_upd),   32'(x.u));
      chk("ptr_err",   32'(bus.ptr_err),   32'(x.e));
      chk("err_cnt",   32'(bus.err_cnt),   32'(x.c));
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    rstn        = 1'b0;
    bus.inp     = 4'b0111;
    bus.err_clr = 1'b0;
    model_reset();
    #3;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // Release with 0111 held: spurious update to 5 on the third edge.
    hold(4'b0111, 4, 1'b0);
    hold(4'b0000, 3, 1'b0);
    hold(4'b0000, 1, 1'b1);
    hold(4'b0001, 3, 1'b0);
    hold(gr(5), 3, 1'b0);
    for (int b = 6; b < 16; b++) step(gr(b), 1'b0);
    hold(4'b0000, 3, 1'b0);
    hold(gr(8), 3, 1'b0);
    hold(gr(13), 3, 1'b0);
    hold(gr(5), 3, 1'b0);
    hold(gr(14), 3, 1'b0);
    hold(gr(14), 1, 1'b1);
    hold(gr(7), 3, 1'b1);
    hold(gr(7), 2, 1'b0);

    // Reset mid-operation while the update strobe is high.
    hold(gr(3), 3, 1'b0);
    #2;
    chk("pre_rst_ptr_upd", 32'(bus.ptr_upd), 32'd1);
    rstn = 1'b0;
    #1;
    q.delete();
    chk_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    src = 3;
    for (int n = 0; n < 400; n++) begin
      int r;
      int stp;
      r = $urandom_range(0, 15);
      if (r < 10)      stp = $urandom_range(0, 4);
      else if (r < 14) stp = $urandom_range(5, 8);
      else             stp = $urandom_range(9, 15);
      src = (src + stp) % 16;
      step(gr(src), ($urandom_range(0, 7) == 0));
    end

    // 300 consecutive illegal advances of 9 to saturate the counter.
    for (int n = 0; n < 300; n++) begin
      src = (src + 9) % 16;
      step(gr(src), 1'b0);
    end
    hold(gr(src), 3, 1'b0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
